// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared types and constants for the logic-analyzer capture path
package la_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_e;

  localparam int LA_ADDR_W = 9;

  function automatic int depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - circular capture RAM writer with pre/post-trigger accounting
module capture_ctrl
  import la_pkg::*;
#(
  parameter int ADDR_W = LA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clr_cap_done,
  input  logic              wrt_smpl,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              triggered,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              armed,
  output logic              set_capture_done,
  output logic              capture_done,
  output logic [ADDR_W-1:0] end_addr
);

  localparam int DEPTH = depth(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  cap_state_e      state;
  logic [ADDR_W:0] smpl_cnt;
  logic [ADDR_W:0] trig_cnt;
  logic [ADDR_W:0] arm_thresh;
  logic            in_cap;
  logic            stop;

  // Extra MSB keeps DEPTH - trig_pos exact even for trig_pos = 0.
  assign arm_thresh       = DEPTH_C - {1'b0, trig_pos};
  assign in_cap           = (state == ST_CAPTURE);
  assign stop             = in_cap & triggered & (trig_cnt == {1'b0, trig_pos});
  assign we               = in_cap & wrt_smpl & ~stop;
  assign set_capture_done = stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      waddr        <= '0;
      smpl_cnt     <= '0;
      trig_cnt     <= '0;
      armed        <= 1'b0;
      capture_done <= 1'b0;
      end_addr     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          waddr    <= '0;
          smpl_cnt <= '0;
          trig_cnt <= '0;
          armed    <= 1'b0;
          if (run) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (stop) begin
            state        <= ST_DONE;
            capture_done <= 1'b1;
            end_addr     <= waddr;
            armed        <= 1'b0;
          end else begin
            armed <= (smpl_cnt >= arm_thresh);
            if (we) begin
              waddr <= waddr + 1'b1;
              if (smpl_cnt != DEPTH_C) smpl_cnt <= smpl_cnt + 1'b1;
              if (triggered) trig_cnt <= trig_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          armed <= 1'b0;
          if (clr_cap_done) begin
            capture_done <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - scoreboard bench for capture_ctrl with a sample-count reference model
module tb_capture_ctrl;

  localparam int AW = 4;
  localparam int D  = 16;
  localparam int M_IDLE = 0, M_CAP = 1, M_DONE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          clr_cap_done = 1'b0;
  logic          wrt_smpl = 1'b0;
  logic [AW-1:0] trig_pos = '0;
  logic          triggered = 1'b0;
  logic          we;
  logic [AW-1:0] waddr;
  logic          armed;
  logic          set_capture_done;
  logic          capture_done;
  logic [AW-1:0] end_addr;

  capture_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clr_cap_done(clr_cap_done),
    .wrt_smpl(wrt_smpl), .trig_pos(trig_pos), .triggered(triggered),
    .we(we), .waddr(waddr), .armed(armed), .set_capture_done(set_capture_done),
    .capture_done(capture_done), .end_addr(end_addr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: counts of accepted samples rather than RTL registers.
  int m_state = M_IDLE;
  int m_n = 0;
  int m_p = 0;
  int m_armed = 0;
  int m_done = 0;
  int m_end = 0;
  int tp = 0;
  bit exp_we = 1'b0;
  bit exp_scd = 1'b0;
  bit mon_en = 1'b0;
  int scd_seen = 0;
  int wq[$];
  int dq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("we", int'(we), int'(exp_we));
      chk("set_capture_done", int'(set_capture_done), int'(exp_scd));
      chk("armed", int'(armed), m_armed);
      chk("capture_done", int'(capture_done), m_done);
      chk("waddr", int'(waddr), m_n % D);
      chk("end_addr", int'(end_addr), m_end);
      if (we) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else chk("write_addr", int'(waddr), wq.pop_front());
      end
      if (set_capture_done) begin
        scd_seen++;
        if (dq.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_addr", int'(waddr), dq.pop_front());
      end
    end
  end

  task automatic step(input bit r, input bit rn, input bit cl, input bit ws, input bit tg);
    bit stp, wr;
    rst_n = r; run = rn; clr_cap_done = cl; wrt_smpl = ws; triggered = tg;
    trig_pos = tp[AW-1:0];
    if (!r) begin
      m_state = M_IDLE; m_n = 0; m_p = 0; m_armed = 0; m_done = 0; m_end = 0;
    end
    stp = (m_state == M_CAP) && tg && (m_p == tp);
    wr  = (m_state == M_CAP) && ws && !stp;
    exp_we = wr;
    exp_scd = stp;
    if (wr) wq.push_back(m_n % D);
    if (stp) dq.push_back(m_n % D);
    @(posedge clk);
    #1;
    if (r) begin
      case (m_state)
        M_IDLE: begin
          m_n = 0; m_p = 0; m_armed = 0;
          if (rn) m_state = M_CAP;
        end
        M_CAP: begin
          if (stp) begin
            m_state = M_DONE; m_done = 1; m_end = m_n % D; m_armed = 0;
          end else begin
            m_armed = (((m_n < D) ? m_n : D) >= D - tp) ? 1 : 0;
            if (wr) begin
              m_n++;
              if (tg) m_p++;
            end
          end
        end
        default: if (cl) begin m_done = 0; m_state = M_IDLE; end
      endcase
    end
  endtask

  task automatic capture_until_done(input int budget, input bit ws_every);
    int k;
    bit tg;
    tg = 1'b1;
    for (k = 0; k < budget && m_state != M_DONE; k++)
      step(1, 0, 0, ws_every ? 1'b1 : 1'($urandom % 2), tg);
    if (m_state != M_DONE) chk("capture_timeout", 0, 1);
    triggered = 1'b0;
  endtask

  initial begin
    int d0;
    #2;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 0, 0, i[0], 0);
    step(1, 0, 0, 1, 0);

    // Arming threshold with trig_pos = 6 is 10 stored samples.
    tp = 6;
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 0);
    chk("armed_before_threshold", int'(armed), 0);
    step(1, 0, 0, 0, 0);
    chk("armed_after_threshold", int'(armed), 1);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    d0 = scd_seen;
    capture_until_done(40, 1);
    chk("normal_end_addr", int'(end_addr), 2);
    chk("normal_done_pulses", scd_seen - d0, 1);
    chk("normal_post_writes", m_n, 18);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    chk("run_in_done_ignored", int'(capture_done), 1);
    step(1, 0, 1, 0, 0);
    chk("clr_done", int'(capture_done), 0);
    step(1, 0, 1, 0, 0);

    // Wrap-around with a long pre-trigger phase.
    step(1, 1, 0, 0, 0);
    chk("restart_waddr", int'(waddr), 0);
    for (int i = 0; i < 40; i++) step(1, 0, 0, 1, 0);
    chk("wrap_waddr", int'(waddr), 8);
    step(1, 0, 0, 0, 0);
    chk("wrap_armed", int'(armed), 1);
    capture_until_done(40, 1);
    chk("wrap_end_addr", int'(end_addr), (40 + 6) % D);
    step(1, 0, 1, 0, 0);

    // trig_pos = 0: stop on first triggered cycle, coincident sample dropped.
    tp = 0;
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(1, 0, 0, 1, 0);
    chk("tp0_armed", int'(armed), 1);
    d0 = scd_seen;
    step(1, 0, 0, 1, 1);
    triggered = 1'b0;
    chk("tp0_done_pulses", scd_seen - d0, 1);
    chk("tp0_end_addr", int'(end_addr), 1);
    step(1, 0, 1, 0, 0);

    // Reset in the middle of a capture.
    tp = 3;
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 0, 0, 1, i > 12);
    d0 = scd_seen;
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    chk("reset_no_done", scd_seen - d0, 0);
    step(1, 0, 0, 1, 0);
    chk("reset_waddr", int'(waddr), 0);

    // Randomised captures with a trigger that fires only once armed.
    for (int c = 0; c < 15; c++) begin
      bit tg;
      int k;
      tp = $urandom_range(0, D - 1);
      tg = 1'b0;
      step(1, 1, 0, 0, 0);
      for (k = 0; k < 400 && m_state != M_DONE; k++) begin
        if (!tg && m_armed != 0 && ($urandom % 4) == 0) tg = 1'b1;
        step(1, ($urandom % 5) == 0, ($urandom % 5) == 0, ($urandom % 3) != 0, tg);
      end
      if (m_state != M_DONE) chk("random_timeout", 0, 1);
      chk("random_post_writes", m_p, tp);
      step(1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0);
    end

    step(1, 0, 0, 0, 0);
    mon_en = 1'b0;
    chk("write_queue_drained", wq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
